// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the Common Data Bus: picks one finished functional unit per
// cycle and registers its reservation-station tag and result onto the broadcast outputs.
module cdb_arbiter #(
    parameter int                N_UF           = 3,
    parameter int                TAG_W          = 3,
    parameter int                DATA_W         = 16,
    parameter logic [TAG_W-1:0]  TAG_SEM_VALOR  = '0,
    parameter logic [DATA_W-1:0] DATA_SEM_VALOR = DATA_W'(16'hFFF0)
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [N_UF-1:0]          Req,
    input  logic [N_UF*TAG_W-1:0]    Tag_in,
    input  logic [N_UF*DATA_W-1:0]   Data_in,
    input  logic                     Flush,
    output logic [N_UF-1:0]          Grant,
    output logic [TAG_W-1:0]         Qi_CDB,
    output logic [DATA_W-1:0]        Qi_CDB_data,
    output logic                     CDB_valid,
    output logic                     Tag_error
);

    localparam int PTR_W = (N_UF > 1) ? $clog2(N_UF) : 1;

    // Handshake: Req[i] is a level-held valid; Grant[i] is the one-cycle accept. The UF
    // keeps Tag_in/Data_in stable while Req[i] is high and moves on at the edge where it
    // sees Grant[i]=1, so a granted unit sits out the following arbitration.

    // Bus mode is a pure function of the grant register; it is kept as a named signal so
    // checkers can bind to it.
    typedef enum logic {
        MODE_IDLE  = 1'b0,
        MODE_BCAST = 1'b1
    } mode_t;

    mode_t             mode;
    logic [PTR_W-1:0]  ptr;
    logic [N_UF-1:0]   bad;
    logic [N_UF-1:0]   elig;
    logic              found;
    logic [N_UF-1:0]   win_onehot;
    logic [PTR_W-1:0]  win_idx;
    logic [TAG_W-1:0]  win_tag;
    logic [DATA_W-1:0] win_data;
    logic [PTR_W-1:0]  next_ptr;

    assign mode      = (|Grant) ? MODE_BCAST : MODE_IDLE;
    assign CDB_valid = (mode == MODE_BCAST);

    always_comb begin
        bad = '0;
        for (int i = 0; i < N_UF; i++) begin
            bad[i] = (Tag_in[i*TAG_W +: TAG_W] == TAG_SEM_VALOR);
        end
        elig = Req & ~Grant & ~bad;
    end

    // Rotating priority in two passes: indices at or above ptr first, then the wrap.
    always_comb begin
        found      = 1'b0;
        win_onehot = '0;
        win_idx    = '0;
        win_tag    = TAG_SEM_VALOR;
        win_data   = DATA_SEM_VALOR;
        for (int i = 0; i < N_UF; i++) begin
            if (!found && elig[i] && (PTR_W'(i) >= ptr)) begin
                found         = 1'b1;
                win_onehot[i] = 1'b1;
                win_idx       = PTR_W'(i);
                win_tag       = Tag_in[i*TAG_W +: TAG_W];
                win_data      = Data_in[i*DATA_W +: DATA_W];
            end
        end
        for (int i = 0; i < N_UF; i++) begin
            if (!found && elig[i]) begin
                found         = 1'b1;
                win_onehot[i] = 1'b1;
                win_idx       = PTR_W'(i);
                win_tag       = Tag_in[i*TAG_W +: TAG_W];
                win_data      = Data_in[i*DATA_W +: DATA_W];
            end
        end
        next_ptr = (win_idx == PTR_W'(N_UF - 1)) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Grant       <= '0;
            Qi_CDB      <= TAG_SEM_VALOR;
            Qi_CDB_data <= DATA_SEM_VALOR;
            ptr         <= '0;
        end else if (Flush) begin
            Grant       <= '0;
            Qi_CDB      <= TAG_SEM_VALOR;
            Qi_CDB_data <= DATA_SEM_VALOR;
            ptr         <= '0;
        end else if (found) begin
            Grant       <= win_onehot;
            Qi_CDB      <= win_tag;
            Qi_CDB_data <= win_data;
            ptr         <= next_ptr;
        end else begin
            Grant       <= '0;
            Qi_CDB      <= TAG_SEM_VALOR;
            Qi_CDB_data <= DATA_SEM_VALOR;
        end
    end

    // A request carrying the no-producer tag is a protocol bug upstream; latch it until reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Tag_error <= 1'b0;
        end else if (|(Req & bad)) begin
            Tag_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with three functional units and hand-computed results.
module tb_cdb_arbiter;

    logic        Clock;
    logic        Reset;
    logic [2:0]  Req;
    logic [8:0]  Tag_in;
    logic [47:0] Data_in;
    logic        Flush;
    logic [2:0]  Grant;
    logic [2:0]  Qi_CDB;
    logic [15:0] Qi_CDB_data;
    logic        CDB_valid;
    logic        Tag_error;

    int vectors;
    int miscompares;

    cdb_arbiter dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Req         (Req),
        .Tag_in      (Tag_in),
        .Data_in     (Data_in),
        .Flush       (Flush),
        .Grant       (Grant),
        .Qi_CDB      (Qi_CDB),
        .Qi_CDB_data (Qi_CDB_data),
        .CDB_valid   (CDB_valid),
        .Tag_error   (Tag_error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_units(input logic [2:0] t0, input logic [2:0] t1, input logic [2:0] t2,
                             input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
        Tag_in  = {t2, t1, t0};
        Data_in = {d2, d1, d0};
    endtask

    task automatic check(input string name, input logic [2:0] exp_grant,
                         input logic [2:0] exp_qi, input logic [15:0] exp_data,
                         input logic exp_err);
        logic exp_valid;
        exp_valid = |exp_grant;
        vectors++;
        assert (Grant === exp_grant) else begin
            miscompares++;
            $error("FAIL %s grant: observed %b expected %b", name, Grant, exp_grant);
        end
        vectors++;
        assert (CDB_valid === exp_valid) else begin
            miscompares++;
            $error("FAIL %s valid: observed %b expected %b", name, CDB_valid, exp_valid);
        end
        vectors++;
        assert (Qi_CDB === exp_qi) else begin
            miscompares++;
            $error("FAIL %s qi: observed %b expected %b", name, Qi_CDB, exp_qi);
        end
        vectors++;
        assert (Qi_CDB_data === exp_data) else begin
            miscompares++;
            $error("FAIL %s data: observed %h expected %h", name, Qi_CDB_data, exp_data);
        end
        vectors++;
        assert (Tag_error === exp_err) else begin
            miscompares++;
            $error("FAIL %s tag_error: observed %b expected %b", name, Tag_error, exp_err);
        end
    endtask

    localparam logic [15:0] IDLE_D = 16'hFFF0;

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset       = 1'b1;
        Flush       = 1'b0;
        Req         = 3'b000;
        set_units(3'd1, 3'd2, 3'd3, 16'h1234, 16'hBBB1, 16'hCCC2);

        tick();
        tick();
        check("reset", 3'b000, 3'b000, IDLE_D, 1'b0);
        Reset = 1'b0;
        tick();
        check("idle_after_reset", 3'b000, 3'b000, IDLE_D, 1'b0);

        // Lone requester: one broadcast every other cycle.
        Req = 3'b001;
        tick(); check("lone_1", 3'b001, 3'd1, 16'h1234, 1'b0);
        tick(); check("lone_2", 3'b000, 3'd0, IDLE_D,   1'b0);
        tick(); check("lone_3", 3'b001, 3'd1, 16'h1234, 1'b0);
        tick(); check("lone_4", 3'b000, 3'd0, IDLE_D,   1'b0);

        // Ptr is 1 here, so UF1 wins first; then reset mid-broadcast.
        Req = 3'b111;
        tick(); check("all_from_ptr1", 3'b010, 3'd2, 16'hBBB1, 1'b0);
        #2 Reset = 1'b1;
        #1 check("async_reset", 3'b000, 3'd0, IDLE_D, 1'b0);
        #1 Reset = 1'b0;

        // After reset Ptr=0: UF0, UF1, UF2, UF0 back to back.
        tick(); check("rr_0", 3'b001, 3'd1, 16'h1234, 1'b0);
        tick(); check("rr_1", 3'b010, 3'd2, 16'hBBB1, 1'b0);
        tick(); check("rr_2", 3'b100, 3'd3, 16'hCCC2, 1'b0);
        tick(); check("rr_3", 3'b001, 3'd1, 16'h1234, 1'b0);

        // Grant UF1 (Ptr->2), idle once, then 011 must wrap to UF0.
        Req = 3'b010;
        tick(); check("pre_wrap_uf1", 3'b010, 3'd2, 16'hBBB1, 1'b0);
        Req = 3'b000;
        tick(); check("pre_wrap_idle", 3'b000, 3'd0, IDLE_D, 1'b0);
        Req = 3'b011;
        tick(); check("wrap_uf0", 3'b001, 3'd1, 16'h1234, 1'b0);

        // Flush with Ptr=2 forces Ptr back to 0, so UF1 beats UF2 afterwards.
        Req = 3'b010;
        tick(); check("pre_flush_uf1", 3'b010, 3'd2, 16'hBBB1, 1'b0);
        Req   = 3'b110;
        Flush = 1'b1;
        tick(); check("flush", 3'b000, 3'd0, IDLE_D, 1'b0);
        Flush = 1'b0;
        tick(); check("post_flush_uf1", 3'b010, 3'd2, 16'hBBB1, 1'b0);
        tick(); check("post_flush_uf2", 3'b100, 3'd3, 16'hCCC2, 1'b0);
        Req = 3'b000;
        tick(); check("post_flush_idle", 3'b000, 3'd0, IDLE_D, 1'b0);

        // UF1 presents the sentinel tag: never granted, error latches.
        set_units(3'd1, 3'd0, 3'd3, 16'h1234, 16'hBBB1, 16'hCCC2);
        Req = 3'b111;
        tick(); check("bad_uf0", 3'b001, 3'd1, 16'h1234, 1'b1);
        tick(); check("bad_uf2", 3'b100, 3'd3, 16'hCCC2, 1'b1);
        tick(); check("bad_uf0_again", 3'b001, 3'd1, 16'h1234, 1'b1);
        Req = 3'b010;
        tick(); check("bad_alone_1", 3'b000, 3'd0, IDLE_D, 1'b1);
        tick(); check("bad_alone_2", 3'b000, 3'd0, IDLE_D, 1'b1);
        Req = 3'b000;

        // Result equal to the idle data value still broadcasts with CDB_valid high.
        set_units(3'd5, 3'd2, 3'd3, 16'hFFF0, 16'hBBB1, 16'hCCC2);
        Req = 3'b001;
        tick(); check("sentinel_data", 3'b001, 3'd5, 16'hFFF0, 1'b1);
        Req = 3'b000;
        tick(); check("sticky_err", 3'b000, 3'd0, IDLE_D, 1'b1);

        #2 Reset = 1'b1;
        #1 check("reset_clears_err", 3'b000, 3'd0, IDLE_D, 1'b0);
        #1 Reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
